uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares a single `uart_tx` serial transmitter between up to 8 byte-producing requesters, such as sample dump, debug print and command echo. It uses round-robin arbitration with optional packet locking, so a multi-byte message is never interleaved with another requester's bytes. The block sits between the producers and the `uart_tx` instance. It drives that instance's `start` and `data` inputs and monitors its `ready` output.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `LOCK_TO`, default 1024: number of idle cycles after which a held packet lock is forcibly released.

Ports:
- `clk`, in, 1: system clock (12 MHz). The block uses one clock domain.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req`, in, NREQ: per-requester byte-valid. Must be held until the matching `ack`.
- `req_data`, in, 8*NREQ: byte of requester i is `req_data[8i+7:8i]`. Must be stable while `req[i]` is high.
- `req_last`, in, NREQ: marks the byte as the end of a packet. Sampled together with the data.
- `ack`, out, NREQ: one-cycle pulse indicating the byte was taken. The requester may change `req_data` on the next cycle.
- `grant_id`, out, 3: index of the current or most recent owner.
- `busy`, out, 1: high from the start pulse until the transmitter reports done.
- `err`, out, 1: one-cycle pulse on a lock timeout or a transmitter handshake fault.
- `tx_start`, out, 1: connects to `uart_tx.start`.
- `tx_data`, out, 8: connects to `uart_tx.data`.
- `tx_ready`, in, 1: connects to `uart_tx.ready`.

## Operation
- FSM states: ARB, START, WAIT_BUSY, WAIT_DONE.
- ARB:
  - If unlocked and `req` is non-zero, pick the first requesting index, searching from `last+1` modulo NREQ.
  - If locked, consider only the lock owner.
  - On a grant, register `grant_id` and go to START. Otherwise stay in ARB.
- START (exactly 1 cycle):
  - `tx_start`=1 and `tx_data` = granted byte.
  - `ack[grant_id]`=1.
  - `last` = `grant_id`.
  - `locked` = ~`req_last[grant_id]`.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for `tx_ready`=0. The transmitter registers `start`, so `ready` stays high for 2 cycles after the start pulse.
  - If `tx_ready` is still high 4 cycles after START, pulse `err` and return to ARB. The lock state is unchanged.
- WAIT_DONE: wait for `tx_ready`=1, then go to ARB.
- `tx_data` holds its value from START until the next START.
- `busy`=1 in START, WAIT_BUSY and WAIT_DONE.
- Lock timeout:
  - While locked in ARB with the owner's `req` low, a counter increments every cycle.
  - When the counter reaches `LOCK_TO`: clear `locked`, pulse `err`, and resume normal round-robin on the next cycle.
  - The counter clears on every START.
- A requester that drops `req` before its `ack` is not served and causes no error.
- When the owner sends a byte with `last`=1, that requester becomes lowest priority in the next arbitration.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0, `ack`=0, `busy`=0, `err`=0, `grant_id`=0.
  - State ARB, `locked`=0, `last`=NREQ-1, so requester 0 wins first.
- Latency: `req` rising in ARB gives `tx_start` and `ack` 1 cycle later.
- Turnaround: `tx_ready` rising gives the next `tx_start` 2 cycles later (one cycle in WAIT_DONE exit, one in ARB).
- `tx_start` is never high for 2 consecutive cycles.
- `tx_start` is never asserted while `tx_ready`=0.
- Simultaneous `req` on all lines with none locked: grants rotate 0, 1, 2, 3, 0, …
- Reset asserted mid-byte:
  - All outputs return to reset values immediately.
  - The in-flight byte is abandoned.
  - The top level resets `uart_tx` with the same reset (`rstn` = ~`rst`).
- The lock-timeout counter is `$clog2(LOCK_TO+1)` bits wide and saturates; it never wraps.

## Structure
- Shared header `uart_arb.vh` holds:
  - FSM state encodings (2 bits).
  - `NREQ_MAX`=8.
  - The WAIT_BUSY guard constant, 4.
- One sub-module, `rr_pick`:
  - Purely combinational round-robin selector.
  - Inputs: `req` mask and `last`. Outputs: `valid` and index.
  - Reusable by other arbiters.
- Everything else (FSM, lock and timeout counter, output registers) lives in `uart_tx_arbiter`.

## Test plan
- Single requester: `req[2]` with byte 0x41, `last`=1.
  - Expect `ack[2]` and `tx_start` 1 cycle later with `tx_data`=0x41, and `busy` high until `tx_ready` rises.
  - Using a real `uart_tx`, a line monitor decodes 0x41.
- All four requesting with `last`=1 and bytes 0x10..0x13.
  - Expect transmit order 0x10, 0x11, 0x12, 0x13, 0x10, with one `ack` per START.
- Packet lock: requester 1 sends a 3-byte packet (`last` on the third byte) while requester 0 requests continuously.
  - Expect all 3 bytes of requester 1 to go before any byte of requester 0.
- Lock timeout: requester 3 sends a byte with `last`=0, then drops `req`; requester 0 is requesting.
  - Expect `err` to pulse after `LOCK_TO` cycles.
  - Expect requester 0 granted 1 cycle later.
- Handshake fault: `tx_ready` stub tied to 1.
  - Expect `err` 4 cycles after `tx_start`, a return to ARB, and no duplicate `ack` for the same byte without a new `req`.
- Reset in WAIT_DONE: assert `rst` mid-byte.
  - Expect all outputs at reset values asynchronously.
  - After release, requester 0 wins first arbitration when all are requesting.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and sizing constants.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_ARB       = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_e;

   localparam int NREQ_MAX = 8;
   // Cycles after the start pulse by which the transmitter must have dropped ready.
   localparam int WB_GUARD = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward from last+1, wrapping at N.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   last,
   output logic         valid,
   output logic [2:0]   idx
);

   logic [NREQ_MAX-1:0] req_x;
   logic [3:0]          cand;

   assign req_x = NREQ_MAX'(req);

   // Scan from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = {1'b0, last} + 4'(k);
         if (cand >= 4'(N)) cand = cand - 4'(N);
         if (req_x[cand[2:0]]) begin
            valid = 1'b1;
            idx   = cand[2:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte producers with round-robin arbitration and packet locking.
//   state        | meaning
//   ST_ARB       | pick next requester (lock owner only while locked), run lock timeout
//   ST_START     | one-cycle start pulse and ack, update last/lock
//   ST_WAIT_BUSY | wait for transmitter to drop ready, fault after WB_GUARD cycles
//   ST_WAIT_DONE | wait for transmitter to raise ready again
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int LOCK_TO = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   ack,
   output logic [2:0]        grant_id,
   output logic              busy,
   output logic              err,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_ready
);

   localparam int              CW     = $clog2(LOCK_TO + 1);
   localparam int              DW     = 8 * NREQ_MAX;
   localparam logic [CW-1:0]   TO_MAX = CW'(LOCK_TO);

   arb_state_e          state_q, state_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          last_q, last_d;
   logic                locked_q, locked_d;
   logic [CW-1:0]       to_cnt_q, to_cnt_d;
   logic [2:0]          wb_cnt_q, wb_cnt_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                err_q, err_d;

   logic [NREQ_MAX-1:0] req_x, req_last_x;
   logic [DW-1:0]       data_x;
   logic                pick_valid;
   logic [2:0]          pick_idx;

   assign req_x      = NREQ_MAX'(req);
   assign req_last_x = NREQ_MAX'(req_last);
   assign data_x     = DW'(req_data);

   rr_pick #(.N(NREQ)) u_rr_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      locked_d  = locked_q;
      to_cnt_d  = to_cnt_q;
      wb_cnt_d  = wb_cnt_q;
      tx_data_d = tx_data_q;
      err_d     = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (locked_q) begin
               if (req_x[grant_q]) begin
                  if (tx_ready) begin
                     tx_data_d = data_x[{grant_q, 3'b000} +: 8];
                     state_d   = ST_START;
                  end
               end else if (to_cnt_q == TO_MAX) begin
                  locked_d = 1'b0;
                  err_d    = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end else if (pick_valid && tx_ready) begin
               grant_d   = pick_idx;
               tx_data_d = data_x[{pick_idx, 3'b000} +: 8];
               state_d   = ST_START;
            end
         end
         ST_START: begin
            last_d   = grant_q;
            locked_d = ~req_last_x[grant_q];
            to_cnt_d = '0;
            wb_cnt_d = 3'd1;
            state_d  = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!tx_ready) begin
               state_d = ST_WAIT_DONE;
            end else if (wb_cnt_q == 3'(WB_GUARD - 1)) begin
               err_d   = 1'b1;
               state_d = ST_ARB;
            end else begin
               wb_cnt_d = wb_cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_ready) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ARB;
         grant_q   <= '0;
         last_q    <= 3'(NREQ - 1);
         locked_q  <= 1'b0;
         to_cnt_q  <= '0;
         wb_cnt_q  <= '0;
         tx_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         locked_q  <= locked_d;
         to_cnt_q  <= to_cnt_d;
         wb_cnt_q  <= wb_cnt_d;
         tx_data_q <= tx_data_d;
         err_q     <= err_d;
      end
   end

   assign tx_start = (state_q == ST_START);
   assign busy     = (state_q != ST_ARB);
   assign ack      = (state_q == ST_START) ? NREQ'(8'b1 << grant_q) : '0;
   assign grant_id = grant_q;
   assign tx_data  = tx_data_q;
   assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx ready stub.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int LOCK_TO = 20;
   localparam int TX_LEN  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   ack;
   logic [2:0]        grant_id;
   logic              busy, err, tx_start;
   logic [7:0]        tx_data;
   logic              tx_ready;
   logic              stub_stuck = 1'b0;
   int                st_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TO(LOCK_TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .err      (err),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (tx_ready)
   );

   always #5 clk = ~clk;

   // Transmitter stub: ready stays high two cycles after start, then low for TX_LEN cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_ready <= 1'b1;
         st_cnt   <= 0;
      end else if (stub_stuck) begin
         tx_ready <= 1'b1;
      end else if (st_cnt == 0) begin
         if (tx_start) st_cnt <= 1;
      end else begin
         st_cnt <= st_cnt + 1;
         if (st_cnt == 2) tx_ready <= 1'b0;
         if (st_cnt == 2 + TX_LEN) begin
            tx_ready <= 1'b1;
            st_cnt   <= 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      req_last = '0;
      req_data = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(input int max, output int dly);
      dly = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (tx_start === 1'b1) begin
            dly = i;
            break;
         end
      end
   endtask

   int dly, e, nst;
   logic [7:0] exp_b [5];
   logic [3:0] exp_a [5];

   initial begin
      // Reset values
      tick();
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_grant", 32'(grant_id), 0);
      rst = 1'b0;

      // Single requester 2, byte 0x41
      req_data[23:16] = 8'h41;
      req_last[2] = 1'b1;
      req[2] = 1'b1;
      wait_start(10, dly);
      chk("single_latency", 32'(dly), 1);
      chk("single_ack", 32'(ack), 32'h4);
      chk("single_data", 32'(tx_data), 32'h41);
      chk("single_grant", 32'(grant_id), 2);
      chk("single_busy_start", 32'(busy), 1);
      tick();
      req[2] = 1'b0;
      chk("single_ack_pulse", 32'(ack), 0);
      chk("single_start_pulse", 32'(tx_start), 0);
      e = 1;
      for (int i = 0; i < 30; i++) begin
         if (busy !== 1'b1) break;
         tick();
         e++;
      end
      chk("single_busy_len", 32'(e), 9);
      chk("single_data_hold", 32'(tx_data), 32'h41);

      // Round-robin over four requesters
      do_reset();
      req_data = 32'h13121110;
      req_last = 4'hF;
      req = 4'hF;
      exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      exp_a = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      for (int k = 0; k < 5; k++) begin
         wait_start(40, dly);
         chk("rr_gap", 32'(dly), (k == 0) ? 1 : 10);
         chk("rr_data", 32'(tx_data), 32'(exp_b[k]));
         chk("rr_ack", 32'(ack), 32'(exp_a[k]));
      end
      req = '0;

      // Packet lock: requester 1 sends three bytes while 0 keeps requesting
      do_reset();
      req_data[7:0]  = 8'hA0;
      req_last[0]    = 1'b1;
      req_data[15:8] = 8'hB1;
      req_last[1]    = 1'b0;
      req = 4'h3;
      exp_b = '{8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hA0};
      exp_a = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h1};
      nst = 0;
      for (int k = 0; k < 5; k++) begin
         wait_start(40, dly);
         chk("lock_data", 32'(tx_data), 32'(exp_b[k]));
         chk("lock_ack", 32'(ack), 32'(exp_a[k]));
         if (ack[1]) begin
            tick();
            nst++;
            if (nst == 1) req_data[15:8] = 8'hB2;
            if (nst == 2) begin
               req_data[15:8] = 8'hB3;
               req_last[1] = 1'b1;
            end
            if (nst == 3) req[1] = 1'b0;
         end
      end
      req = '0;

      // Lock timeout: requester 3 opens a packet then abandons it
      do_reset();
      req_data[31:24] = 8'h33;
      req_last[3] = 1'b0;
      req[3] = 1'b1;
      wait_start(10, dly);
      chk("to_first_ack", 32'(ack), 32'h8);
      tick();
      req[3] = 1'b0;
      req_data[7:0] = 8'h05;
      req_last[0] = 1'b1;
      req[0] = 1'b1;
      e = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         e++;
         if (err === 1'b1) break;
      end
      chk("to_err_delay", 32'(e), LOCK_TO + 10);
      tick();
      chk("to_err_pulse", 32'(err), 0);
      chk("to_grant_start", 32'(tx_start), 1);
      chk("to_grant_ack", 32'(ack), 32'h1);
      chk("to_grant_data", 32'(tx_data), 32'h05);
      req = '0;

      // Handshake fault: ready never drops
      stub_stuck = 1'b1;
      do_reset();
      req_data[23:16] = 8'h77;
      req_last[2] = 1'b1;
      req[2] = 1'b1;
      wait_start(10, dly);
      chk("hs_ack", 32'(ack), 32'h4);
      tick();
      req[2] = 1'b0;
      e = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         e++;
         if (err === 1'b1) break;
      end
      chk("hs_err_delay", 32'(e), 4);
      chk("hs_busy_cleared", 32'(busy), 0);
      nst = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_start === 1'b1 || ack !== '0) nst++;
      end
      chk("hs_no_dup_ack", 32'(nst), 0);
      stub_stuck = 1'b0;

      // Reset while waiting for the transmitter to finish
      do_reset();
      req_data = 32'h13121110;
      req_last = 4'hF;
      req = 4'hF;
      wait_start(10, dly);
      chk("mid_first_data", 32'(tx_data), 32'h10);
      tick();
      tick();
      tick();
      tick();
      chk("mid_busy_before", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx_start", 32'(tx_start), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ack", 32'(ack), 0);
      chk("mid_rst_tx_data", 32'(tx_data), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_grant", 32'(grant_id), 0);
      #2 rst = 1'b0;
      wait_start(10, dly);
      chk("mid_after_latency", 32'(dly), 1);
      chk("mid_after_ack", 32'(ack), 32'h1);
      chk("mid_after_data", 32'(tx_data), 32'h10);
      req = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
